viterbi_simple_v2: RTL and testbench

Frame-based hard-decision Viterbi decoder for a rate-1/2 convolutional code with constraint length K. It takes a whole frame of 2-bit received symbols as a parallel array, runs add-compare-select (ACS) over the trellis one step per cycle, then traces back one step per cycle. It presents the decoded bit array with a sticky done flag. It serves as the golden/simple decoder used in block-level decoder tests.

---
 rtl/viterbi_simple_v2.sv | 186 ++++++++++++++++++
 tb/tb_viterbi_simple_v2.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_simple_v2.sv
// viterbi_simple_v2 - frame-based hard-decision Viterbi decoder, rate 1/2.
//
// Decodes a whole frame of received 2-bit symbols held on a parallel array.
// One add-compare-select step over all trellis states per cycle, then one
// traceback step per cycle, then the decoded bits are held with a sticky done.
//
// Encoder being inverted: state st (M bits) starts at 0; for input u,
// r = {st,u}, symbol = {^(r&G0), ^(r&G1)}, next state = {st[M-2:0],u}.
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-low reset
//   start      one-cycle pulse, accepted only in IDLE or DONE
//   frame_len  frame length in symbols, latched when start is accepted
//   syms_in    received symbols, syms_in[t] = {c0,c1}; held until done
//   done       high once the decoded frame is available
//   out_len    decoded length (latched frame_len)
//   bits_out   decoded bits, bits_out[t] = info bit at time t; 0 beyond len
module viterbi_simple_v2 #(
    parameter int             K  = 3,
    parameter logic [K-1:0]   G0 = 3'b111,
    parameter logic [K-1:0]   G1 = 3'b101
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] frame_len,
    input  logic [1:0] syms_in [0:255],
    output logic       done,
    output logic [7:0] out_len,
    output logic       bits_out [0:255]
);

    localparam int M = K - 1;
    localparam int S = 1 << M;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACS       = 2'd1,
        TRACEBACK = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t       state;
    logic [7:0]   t;
    logic [7:0]   len;
    logic [M-1:0] tb_state;

    logic [11:0]  metric [S];
    logic [S-1:0] surv   [0:256-1];

    logic [11:0]  cand0      [S];
    logic [11:0]  cand1      [S];
    logic [11:0]  new_metric [S];
    logic [S-1:0] new_surv;
    logic [M-1:0] best_state;
    logic [11:0]  best_m;
    logic         accept;

    // Predecessor of state ns when the bit shifted out of the encoder was x.
    function automatic logic [M-1:0] pred(input logic [M-1:0] ns, input logic x);
        return {x, ns[M-1:1]};
    endfunction

    // Hamming distance between the symbol the encoder emits leaving state p
    // on input u and the received symbol.
    function automatic logic [1:0] branch_metric(input logic [M-1:0] p,
                                                 input logic       u,
                                                 input logic [1:0] sym);
        logic [K-1:0] r;
        logic [1:0]   d;
        r = {p, u};
        d = {^(r & G0), ^(r & G1)} ^ sym;
        return {1'b0, d[1]} + {1'b0, d[0]};
    endfunction

    assign accept = start && (state == IDLE || state == DONE);

    // NOTE: every variable written here gets a value on every pass through the
    // block (the loops cover all indices, scalars are set up front), so no
    // latches are inferred; blocking assignments are correct in combinational
    // logic because later statements must see the earlier results.
    always_comb begin
        new_surv   = '0;
        for (int i = 0; i < S; i++) begin
            cand0[i] = metric[pred(i[M-1:0], 1'b0)]
                     + 12'(branch_metric(pred(i[M-1:0], 1'b0), i[0], syms_in[t]));
            cand1[i] = metric[pred(i[M-1:0], 1'b1)]
                     + 12'(branch_metric(pred(i[M-1:0], 1'b1), i[0], syms_in[t]));
            // Tie goes to the x=0 predecessor.
            if (cand0[i] <= cand1[i]) begin
                new_metric[i] = cand0[i];
                new_surv[i]   = 1'b0;
            end else begin
                new_metric[i] = cand1[i];
                new_surv[i]   = 1'b1;
            end
        end

        // Strict compare keeps the lowest index on equal metrics.
        best_state = '0;
        best_m     = new_metric[0];
        for (int i = 1; i < S; i++) begin
            if (new_metric[i] < best_m) begin
                best_m     = new_metric[i];
                best_state = i[M-1:0];
            end
        end
    end

    // NOTE: path metrics and survivor memory carry no reset; every frame
    // initialises the metrics on start and writes each survivor row before
    // traceback reads it, so reset logic here would only cost fan-out.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < S; i++) begin
                metric[i] <= (i == 0) ? 12'd0 : 12'd1023;
            end
        end else if (state == ACS) begin
            metric  <= new_metric;
            surv[t] <= new_surv;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            t        <= '0;
            len      <= '0;
            tb_state <= '0;
            done     <= 1'b0;
            out_len  <= '0;
            for (int i = 0; i < 256; i++) begin
                bits_out[i] <= 1'b0;
            end
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (state == DONE) begin
                        done    <= 1'b1;
                        out_len <= len;
                    end
                    // Later assignments below override the DONE hold on start.
                    if (start) begin
                        len  <= frame_len;
                        t    <= '0;
                        done <= 1'b0;
                        for (int i = 0; i < 256; i++) begin
                            bits_out[i] <= 1'b0;
                        end
                        if (frame_len == 8'd0) begin
                            state   <= DONE;
                            out_len <= '0;
                        end else begin
                            state <= ACS;
                        end
                    end
                end

                ACS: begin
                    if (t == len - 8'd1) begin
                        tb_state <= best_state;
                        state    <= TRACEBACK;
                    end else begin
                        t <= t + 8'd1;
                    end
                end

                TRACEBACK: begin
                    bits_out[t] <= tb_state[0];
                    tb_state    <= {surv[t][tb_state], tb_state[M-1:1]};
                    if (t == 8'd0) begin
                        state <= DONE;
                    end else begin
                        t <= t - 8'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_viterbi_simple_v2.sv
// Self-checking bench for viterbi_simple_v2.
// Two instances: default K=3 (111/101) and K=4 (1111/1101). Messages are
// encoded by a behavioural encoder; the decoder must return the message
// exactly for error-free frames and frames with isolated single bit errors.
module tb_viterbi_simple_v2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       start3 = 1'b0;
    logic [7:0] len3   = '0;
    logic [1:0] syms3 [0:255];
    logic       done3;
    logic [7:0] out_len3;
    logic       bits3 [0:255];

    logic       start4 = 1'b0;
    logic [7:0] len4   = '0;
    logic [1:0] syms4 [0:255];
    logic       done4;
    logic [7:0] out_len4;
    logic       bits4 [0:255];

    int n_checks = 0;
    int n_fail   = 0;

    logic [255:0] msg;
    logic [1:0]   stage [0:255];

    always #5 clk = ~clk;

    viterbi_simple_v2 dut3 (
        .clk       (clk),
        .rst       (rst),
        .start     (start3),
        .frame_len (len3),
        .syms_in   (syms3),
        .done      (done3),
        .out_len   (out_len3),
        .bits_out  (bits3)
    );

    viterbi_simple_v2 #(.K(4), .G0(4'b1111), .G1(4'b1101)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .start     (start4),
        .frame_len (len4),
        .syms_in   (syms4),
        .done      (done4),
        .out_len   (out_len4),
        .bits_out  (bits4)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] packed_bits(input int sel);
        logic [255:0] v;
        for (int i = 0; i < 256; i++) v[i] = (sel == 4) ? bits4[i] : bits3[i];
        return v;
    endfunction

    function automatic logic get_done(input int sel);
        return (sel == 4) ? done4 : done3;
    endfunction

    function automatic logic [7:0] get_out_len(input int sel);
        return (sel == 4) ? out_len4 : out_len3;
    endfunction

    // Keep only the first len message bits.
    task automatic mask_msg(input int len);
        for (int i = 0; i < 256; i++) if (i >= len) msg[i] = 1'b0;
    endtask

    // Behavioural convolutional encoder: message -> stage symbols.
    task automatic encode(input int k, input int g0, input int g1, input int len);
        int st;
        int r;
        logic c0;
        logic c1;
        st = 0;
        for (int i = 0; i < 256; i++) stage[i] = 2'b00;
        for (int i = 0; i < len; i++) begin
            r  = (st << 1) | (msg[i] ? 1 : 0);
            c0 = ($countones(r & g0) % 2) == 1;
            c1 = ($countones(r & g1) % 2) == 1;
            stage[i] = {c0, c1};
            st = r & ((1 << (k - 1)) - 1);
        end
    endtask

    // Present stage symbols and pulse start; returns #1 after the start edge.
    task automatic launch(input int sel, input int len);
        @(negedge clk);
        if (sel == 4) begin
            syms4 = stage; len4 = 8'(len); start4 = 1'b1;
        end else begin
            syms3 = stage; len3 = 8'(len); start3 = 1'b1;
        end
        @(posedge clk); #1;
        start3 = 1'b0;
        start4 = 1'b0;
    endtask

    // Count edges until done is seen, bounded.
    task automatic wait_done(input int sel, output int cycles);
        cycles = 0;
        while (!get_done(sel) && cycles < 600) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (!get_done(sel)) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: done not seen after %0d cycles", cycles);
        end
    endtask

    task automatic check_result(input string tag, input int sel, input int len);
        check({tag, "_done"},    256'(get_done(sel)), 256'(1));
        check({tag, "_out_len"}, 256'(get_out_len(sel)), 256'(len));
        check({tag, "_bits"},    packed_bits(sel), msg);
    endtask

    task automatic random_msg();
        for (int i = 0; i < 8; i++) msg[i*32 +: 32] = $urandom;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int len;
        int pos;

        for (int i = 0; i < 256; i++) begin
            syms3[i] = 2'b00;
            syms4[i] = 2'b00;
            stage[i] = 2'b00;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_done",    256'(done3), 256'(0));
        check("rst_out_len", 256'(out_len3), 256'(0));
        check("rst_bits",    packed_bits(3), 256'(0));
        check("rst_state",   256'(dut3.state), 256'(0));
        @(negedge clk);
        rst = 1'b1;

        // K=4 impulse at t=12, len 32
        msg = '0;
        msg[12] = 1'b1;
        encode(4, 'b1111, 'b1101, 32);
        launch(4, 32);
        wait_done(4, cyc);
        check("k4_latency", 256'(cyc), 256'(65));
        check_result("k4_impulse", 4, 32);

        // K=3 all-zero symbols, len 16
        msg = '0;
        encode(3, 'b111, 'b101, 16);
        launch(3, 16);
        wait_done(3, cyc);
        check("zero_latency", 256'(cyc), 256'(33));
        check_result("zero", 3, 16);

        // K=3 random 64-bit message, single flipped symbol bit at t=20
        random_msg();
        mask_msg(64);
        encode(3, 'b111, 'b101, 64);
        stage[20][$urandom_range(0, 1)] ^= 1'b1;
        launch(3, 64);
        wait_done(3, cyc);
        check("err1_latency", 256'(cyc), 256'(129));
        check_result("err1", 3, 64);

        // Back-to-back: start while in DONE with a shorter frame
        random_msg();
        mask_msg(20);
        encode(3, 'b111, 'b101, 20);
        launch(3, 20);
        check("b2b_done_drop", 256'(done3), 256'(0));
        wait_done(3, cyc);
        check("b2b_latency", 256'(cyc), 256'(41));
        check_result("b2b", 3, 20);

        // frame_len = 0 with garbage symbols
        msg = '0;
        for (int i = 0; i < 256; i++) stage[i] = 2'($urandom);
        launch(3, 0);
        wait_done(3, cyc);
        check("len0_latency", 256'(cyc), 256'(1));
        check_result("len0", 3, 0);

        // Reset during ACS, then a clean decode
        random_msg();
        mask_msg(64);
        encode(3, 'b111, 'b101, 64);
        launch(3, 64);
        repeat (10) @(posedge clk);
        #1;
        check("mid_state_acs", 256'(dut3.state), 256'(1));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_state",   256'(dut3.state), 256'(0));
        check("mid_rst_t",       256'(dut3.t), 256'(0));
        check("mid_rst_done",    256'(done3), 256'(0));
        check("mid_rst_out_len", 256'(out_len3), 256'(0));
        check("mid_rst_bits",    packed_bits(3), 256'(0));
        @(negedge clk);
        rst = 1'b1;
        launch(3, 64);
        wait_done(3, cyc);
        check("post_rst_latency", 256'(cyc), 256'(129));
        check_result("post_rst", 3, 64);

        // start pulsed during ACS is ignored
        random_msg();
        mask_msg(40);
        encode(3, 'b111, 'b101, 40);
        launch(3, 40);
        repeat (5) @(posedge clk);
        @(negedge clk);
        len3   = 8'd5;
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        wait_done(3, cyc);
        check_result("ign_start", 3, 40);

        // Random frames, isolated single error on longer ones
        for (int n = 0; n < 10; n++) begin
            len = $urandom_range(1, 120);
            random_msg();
            mask_msg(len);
            encode(3, 'b111, 'b101, len);
            if (len >= 40) begin
                pos = $urandom_range(3, len - 25);
                stage[pos][$urandom_range(0, 1)] ^= 1'b1;
            end
            launch(3, len);
            wait_done(3, cyc);
            check("rnd_latency", 256'(cyc), 256'(2 * len + 1));
            check_result("rnd", 3, len);
        end

        // Random K=4 frames, error-free
        for (int n = 0; n < 4; n++) begin
            len = $urandom_range(1, 90);
            random_msg();
            mask_msg(len);
            encode(4, 'b1111, 'b1101, len);
            launch(4, len);
            wait_done(4, cyc);
            check("rnd4_latency", 256'(cyc), 256'(2 * len + 1));
            check_result("rnd4", 4, len);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
